// File: rtl/serial_in_parallel_out_deser.sv
// Serial-to-parallel receiver: assembles LSB-first bits into DATA_WIDTH-bit words and
// presents them through a one-entry valid/ready holding register with sticky overflow.
module serial_in_parallel_out_deser #(
  parameter  int DATA_WIDTH = 16,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  align,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  output logic [CNT_W-1:0]      bit_cnt
);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d;

  logic                  last_bit;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;

  assign last_bit  = (cnt_q == CNT_W'(DATA_WIDTH-1));
  assign word      = {din, sreg_q[DATA_WIDTH-1:1]};
  // align pre-empts completion so a re-framed stream never emits the stale partial word
  assign word_done = din_en & ~align & last_bit;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;

    if (align) begin
      sreg_d = '0;
      if (din_en) begin
        sreg_d[DATA_WIDTH-1] = din;
        cnt_d                = CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (din_en) begin
      sreg_d = word;
      cnt_d  = last_bit ? '0 : cnt_q + CNT_W'(1);
    end

    if (vld_q & dout_ready) vld_d = 1'b0;
    if (ovf_clr)            ovf_d = 1'b0;

    // a load in the draining cycle keeps valid high, giving full-rate back-to-back words
    if (word_done) begin
      if (!vld_q || dout_ready) begin
        dout_d = word;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign overflow   = ovf_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_in_parallel_out_deser.sv
// Directed bench for the deserializer: a bit-queue model checked every cycle, plus
// literal expectations for the key scenarios.
module tb_serial_in_parallel_out_deser;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn, din, din_en, align, ovf_clr, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, overflow;
  logic [3:0]   bit_cnt;

  serial_in_parallel_out_deser #(.DATA_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .align(align),
    .ovf_clr(ovf_clr), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overflow(overflow), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: received bits of the partial word, and the holding register
  bit           mq[$];
  logic [W-1:0] m_dout;
  logic         m_vld, m_ovf;
  logic [W-1:0] xq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic         v0, done;
    logic [W-1:0] w;
    v0   = m_vld;
    done = 1'b0;
    w    = '0;
    if (!resetn) begin
      mq.delete();
      m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0;
    end else begin
      if (align) begin
        mq.delete();
        if (din_en) mq.push_back(din);
      end else if (din_en) begin
        mq.push_back(din);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = mq[i];
          mq.delete();
          done = 1'b1;
        end
      end
      if (v0 && dout_ready) m_vld = 1'b0;
      if (ovf_clr) m_ovf = 1'b0;
      if (done) begin
        if (!v0 || dout_ready) begin m_dout = w; m_vld = 1'b1; end
        else m_ovf = 1'b1;
      end
    end
  endtask

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic cyc();
    if (resetn && dout_valid && dout_ready) xq.push_back(dout);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dout",       32'(dout),       32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_vld));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("bit_cnt",    32'(bit_cnt),    32'(mq.size()));
  endtask

  task automatic send(input logic [W-1:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      din = w[i]; din_en = 1'b1;
      cyc();
      din_en = 1'b0;
      for (int g = 0; g < gap; g++) begin
        cyc();
        if (gap == 3 && i == 7) chk("gap_hold_cnt", 32'(bit_cnt), 32'd8);
      end
    end
    din = 1'b0;
  endtask

  task automatic drain();
    dout_ready = 1'b1; cyc(); dout_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; din = 1'b0; din_en = 1'b0; align = 1'b0; ovf_clr = 1'b0; dout_ready = 1'b0;
    m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0;
    cyc(); cyc();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_vld",  32'(dout_valid), 32'd0);
    chk("rst_cnt",  32'(bit_cnt), 32'd0);
    resetn = 1'b1;

    // 1: contiguous word
    send(16'hA5C3, 15, 0);
    chk("t1_no_early_vld", 32'(dout_valid), 32'd0);
    send(16'hA5C3 >> 15, 1, 0);
    chk("t1_dout", 32'(dout), 32'hA5C3);
    chk("t1_vld",  32'(dout_valid), 32'd1);
    chk("t1_cnt",  32'(bit_cnt), 32'd0);
    chk("t1_ovf",  32'(overflow), 32'd0);
    drain();

    // 2: three idle cycles between bits
    send(16'hA5C3, 16, 3);
    chk("t2_dout", 32'(dout), 32'hA5C3);
    drain();

    // 3: back-to-back words, consumer always ready
    xq.delete();
    dout_ready = 1'b1;
    send(16'h1234, 16, 0);
    send(16'hFFFF, 16, 0);
    send(16'h0001, 16, 0);
    cyc(); cyc();
    chk("t3_nxfer", 32'(xq.size()), 32'd3);
    if (xq.size() == 3) begin
      chk("t3_x0", 32'(xq[0]), 32'h1234);
      chk("t3_x1", 32'(xq[1]), 32'hFFFF);
      chk("t3_x2", 32'(xq[2]), 32'h0001);
    end
    chk("t3_ovf", 32'(overflow), 32'd0);
    dout_ready = 1'b0;

    // 4: second word dropped while holding full
    send(16'hBEEF, 16, 0);
    send(16'hCAFE, 16, 0);
    chk("t4_dout", 32'(dout), 32'hBEEF);
    chk("t4_ovf",  32'(overflow), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    send(16'h1111, 16, 0);
    ovf_clr = 1'b0;
    chk("t4_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    drain();

    // 5: align with a bit re-frames the word
    send(16'h001F, 5, 0);
    align = 1'b1; din = 1'b1; din_en = 1'b1; cyc();
    align = 1'b0; din_en = 1'b0;
    chk("t5_cnt_align", 32'(bit_cnt), 32'd1);
    send(16'h8001 >> 1, 15, 0);
    chk("t5_dout", 32'(dout), 32'h8001);
    chk("t5_vld",  32'(dout_valid), 32'd1);
    drain();
    // align on the would-be last bit suppresses the word; align alone zeroes the count
    send(16'h7777, 15, 0);
    align = 1'b1; din = 1'b0; din_en = 1'b1; cyc();
    chk("t5_no_word", 32'(dout_valid), 32'd0);
    chk("t5_cnt1",    32'(bit_cnt), 32'd1);
    din_en = 1'b0; cyc(); align = 1'b0;
    chk("t5_cnt0",    32'(bit_cnt), 32'd0);

    // 6: reset mid-word with holding full
    send(16'h3C3C, 16, 0);
    send(16'h01FF, 9, 0);
    resetn = 1'b0; cyc(); resetn = 1'b1;
    chk("t6_dout", 32'(dout), 32'd0);
    chk("t6_vld",  32'(dout_valid), 32'd0);
    chk("t6_cnt",  32'(bit_cnt), 32'd0);
    send(16'h5A5A, 16, 0);
    chk("t6_word", 32'(dout), 32'h5A5A);
    chk("t6_vld2", 32'(dout_valid), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
